// File: rtl/board_ws2812_driver.sv
// board_ws2812_driver
//   Renders the 8x8 life board onto a chained WS2812-style LED matrix.
//   On an accepted start the board is snapshotted. Each cell becomes a 24-bit
//   GRB word: ON_COLOR if the cell is alive, 0 if it is dead. The 64 words are
//   sent MSB first using single-wire NRZ bit cells. The line is then held low
//   for the latch period.
//
//   Optional feature (compile-time macro SERPENTINE_EN):
//     When defined, odd rows are read right-to-left so that boustrophedon-wired
//     matrices display correctly. When undefined, pixels follow linear order.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   board[63:0] in  cell states, cell (r,c) = board[r*8+c]
//   start      in   frame request, honoured only while ready=1
//   ready      out  high while idle
//   frame_done out  one-cycle pulse on the last latch cycle
//   dout       out  registered serial LED data
module board_ws2812_driver #(
  parameter int          T0H_CYCLES   = 4,
  parameter int          T1H_CYCLES   = 8,
  parameter int          BIT_CYCLES   = 15,
  parameter int          RESET_CYCLES = 600,
  parameter logic [23:0] ON_COLOR     = 24'h001000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] board,
  input  logic        start,
  output logic        ready,
  output logic        frame_done,
  output logic        dout
);

  localparam int MAX_CYC = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] RESET_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] T0H_LEN    = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] T1H_LEN    = CW'(T1H_CYCLES);

  generate
    if (!((T0H_CYCLES > 0) && (T0H_CYCLES < T1H_CYCLES) &&
          (T1H_CYCLES < BIT_CYCLES) && (RESET_CYCLES >= 1))) begin : g_bad_timing
      $error("board_ws2812_driver: need 0 < T0H < T1H < BIT_CYCLES and RESET_CYCLES >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t      state_q,  state_d;
  logic [63:0] shadow_q, shadow_d;
  logic [5:0]  pix_q,    pix_d;
  logic [4:0]  bit_q,    bit_d;
  logic [CW-1:0] cyc_q,  cyc_d;
  logic        dout_q,   dout_d;
  logic        ready_q,  ready_d;
  logic        done_q,   done_d;

  logic [5:0]  cell_idx;
  logic        bit_val;
  logic [CW-1:0] high_len;

  // Next-state logic. The bit counter counts up 0..23 and the transmitted
  // bit index is 23 - bit, which gives MSB-first order (G, then R, then B).
  // The registered outputs are derived from the *next* counters so that they
  // line up with the counter values of the cycle in which they are visible.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    pix_d    = pix_q;
    bit_d    = bit_q;
    cyc_d    = cyc_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d = board;
          pix_d    = '0;
          bit_d    = '0;
          cyc_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d = '0;
          if (bit_q == 5'd23) begin
            bit_d = '0;
            // The pixel counter parks at 63 rather than wrapping into a 65th pixel.
            if (pix_q == 6'd63) begin
              state_d = LATCH;
            end else begin
              pix_d = pix_q + 6'd1;
            end
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      LATCH: begin
        if (cyc_q == RESET_LAST) begin
          cyc_d   = '0;
          state_d = IDLE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef SERPENTINE_EN
    // Odd rows (pix[3] set) run right-to-left on a boustrophedon matrix.
    cell_idx = {pix_d[5:3], pix_d[2:0] ^ {3{pix_d[3]}}};
`else
    cell_idx = pix_d;
`endif

    bit_val  = shadow_d[cell_idx] & ON_COLOR[5'd23 - bit_d];
    high_len = bit_val ? T1H_LEN : T0H_LEN;

    dout_d  = (state_d == SEND) && (cyc_d < high_len);
    ready_d = (state_d == IDLE);
    done_d  = (state_d == LATCH) && (cyc_d == RESET_LAST);
  end

  // Single state register. Reset drops dout immediately and discards any
  // frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      pix_q    <= '0;
      bit_q    <= '0;
      cyc_q    <= '0;
      dout_q   <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      pix_q    <= pix_d;
      bit_q    <= bit_d;
      cyc_q    <= cyc_d;
      dout_q   <= dout_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign dout       = dout_q;
  assign ready      = ready_q;
  assign frame_done = done_q;

endmodule
